time_set_controller: RTL and testbench
======================================

Name: time_set_controller

Overview:
- Input side of the standby time-setting path. Conditions the raw push-buttons and edits the reminder threshold (hours/minutes) and the gesture time (seconds).
- Drives hour_threshold, min_threshold, second_gesture and adjust_state to the time-set display and to the reminder/gesture logic.
- Runs on clk_500Hz: 2 ms per cycle.

Parameters:
- DEBOUNCE_CYCLES, 10, consecutive stable synchronized samples before a debounced level changes (20 ms).
- REPEAT_DELAY, 250, cycles of continuous debounced hold before the first auto-repeat step (0.5 s).
- REPEAT_PERIOD, 50, cycles between subsequent auto-repeat steps (0.1 s).
- DEF_HOUR, 10, reset value of hour_threshold.
- DEF_MIN, 0, reset value of min_threshold.
- DEF_GESTURE, 5, reset value of second_gesture.

Ports:
- clk_500Hz  in  1  system clock, 500 Hz.
- rst_n  in  1  reset.
- btn_inc  in  1  raw increment button, active-high, asynchronous.
- btn_dec  in  1  raw decrement button, active-high, asynchronous.
- btn_select  in  1  raw field-select button, active-high, asynchronous.
- is_standby  in  1  editing is enabled only when this is high.
- reminder_duration_set_switch  in  1  reminder edit mode.
- gesture_time_set_switch  in  1  gesture edit mode.
- hour_threshold  out  6  reminder hours, 0..23.
- min_threshold  out  6  reminder minutes, 0..59.
- second_gesture  out  6  gesture seconds, 1..59.
- adjust_state  out  2  00 = ADJUST_MIN_REMINDER, 01 = ADJUST_HOUR_REMINDER.
- settings_saved  out  1  one-cycle pulse on leaving an edit mode.

Interface note: reset rst_n, asynchronous, active-low; clock clk_500Hz.

Behaviour:
- Reset values: hour_threshold=DEF_HOUR, min_threshold=DEF_MIN, second_gesture=DEF_GESTURE, adjust_state=00, settings_saved=0. All conditioner state (counters, debounced levels, repeat timers) is cleared.
- Conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter: the debounced level takes the synchronized value after DEBOUNCE_CYCLES consecutive equal samples differing from the current level. Any mismatching sample restarts the count.
  - Step pulse on a debounced 0->1 transition.
- Auto-repeat, inc/dec only:
  - While the debounced level stays high, a hold counter runs from the debounced rise.
  - Additional pulses at hold count REPEAT_DELAY, then every REPEAT_PERIOD.
  - The counter saturates and does not wrap into spurious pulses.
  - btn_select never repeats.
- Latency: a raw press stable from edge 0 produces the step pulse at edge 2+DEBOUNCE_CYCLES. The output register updates at the following edge.
- Mode decode, evaluated each cycle:
  - REMINDER = is_standby & reminder_duration_set_switch. Reminder has priority when both switches are high.
  - GESTURE = is_standby & ~reminder_duration_set_switch & gesture_time_set_switch.
  - IDLE otherwise.
- IDLE:
  - All pulses are ignored and values hold.
  - adjust_state is forced to 00.
- REMINDER:
  - select pulse toggles adjust_state 00<->01.
  - inc/dec act on the minute field when adjust_state=00 and on the hour field when adjust_state=01.
- GESTURE:
  - inc/dec act on second_gesture.
  - adjust_state holds 00.
- Wrap rules:
  - Minutes: 59+1 -> 0, 0-1 -> 59.
  - Hours: 23+1 -> 0, 0-1 -> 23.
  - Gesture: 59+1 -> 1, 1-1 -> 59. 0 is never produced.
- Simultaneous events:
  - inc and dec pulses in the same cycle: no change.
  - select with inc/dec in the same cycle: the step applies to the field selected before the toggle, and the toggle takes effect at the same edge.
- settings_saved pulses for one cycle when the mode transitions REMINDER->IDLE, GESTURE->IDLE or REMINDER->GESTURE. No pulse on GESTURE->REMINDER.
- Reset mid-operation (e.g., during a hold) returns all state to the reset values. After release of reset, no pulse is generated until a fresh debounced rise.
- Buttons held across a mode change keep their conditioner state. Repeat pulses act on the new mode.

Decomposition:
- Shared package holds:
  - ADJUST_MIN_REMINDER=2'b00, ADJUST_HOUR_REMINDER=2'b01 (the display module uses the same encodings).
  - Limits HOUR_MAX=23, MIN_MAX=59, GESTURE_MIN=1, GESTURE_MAX=59.
  - Mode encoding IDLE/REMINDER/GESTURE.
- Sub-module button_conditioner (synchronizer + debounce + edge detect + optional repeat, parameter REPEAT_EN), instantiated three times.
- Top level holds the mode decode, the field registers and the save pulse.

Test Plan:
- Reset -> hour=10, min=0, gesture=5, adjust_state=00, settings_saved=0; values hold with no presses for 1000 cycles.
- is_standby=1, reminder switch=1; three clean inc presses of 20 cycles each -> min=3. A 4-cycle glitch on btn_inc -> min stays 3. Update occurs exactly 13 edges after the raw rise.
- min=59, inc -> min=0. select -> adjust_state=01. hour=0, dec -> hour=23. Simultaneous inc+dec -> hour unchanged.
- Gesture mode, second_gesture=5; hold inc for 499 cycles after the debounced rise -> steps at hold counts 0, 250, 300, 350, 400, 450 -> second_gesture=11. Then from 59, one inc -> 1.
- is_standby=0 with presses -> no change. Both switches high -> the minute field is edited. Reminder switch 1->0 -> one-cycle settings_saved and adjust_state=00.
- Assert rst_n mid-hold with min=7 -> min=0 immediately. Keep the button held through the reset release -> no step occurs until release and a new press.

Source files
------------

// File: rtl/time_set_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : time_set_controller_pkg
//  Description : Shared encodings, field limits and wrap helper for the
//                standby time-setting path.
//  Revision    : 1.0 - initial release
// ============================================================================
package time_set_controller_pkg;

    // Shared with the time-set display module; the encodings must not change.
    localparam logic [1:0] ADJUST_MIN_REMINDER  = 2'b00;
    localparam logic [1:0] ADJUST_HOUR_REMINDER = 2'b01;

    localparam logic [5:0] HOUR_MAX    = 6'd23;
    localparam logic [5:0] MIN_MAX     = 6'd59;
    localparam logic [5:0] GESTURE_MIN = 6'd1;
    localparam logic [5:0] GESTURE_MAX = 6'd59;

    localparam int unsigned MODE_W = 2;
    localparam logic [MODE_W-1:0] MODE_IDLE     = 2'd0;
    localparam logic [MODE_W-1:0] MODE_REMINDER = 2'd1;
    localparam logic [MODE_W-1:0] MODE_GESTURE  = 2'd2;

    typedef struct packed {
        logic inc;
        logic dec;
        logic sel;
    } step_t;

    // One-step wrap-around edit of a bounded field; opposing steps cancel.
    function automatic logic [5:0] step_field(
        input logic [5:0] val,
        input logic       up,
        input logic       dn,
        input logic [5:0] lo,
        input logic [5:0] hi
    );
        logic [5:0] res;
        res = val;
        if (up && !dn) begin
            res = (val >= hi) ? lo : val + 6'd1;
        end else if (dn && !up) begin
            res = (val <= lo) ? hi : val - 6'd1;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/time_set_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : time_set_controller_if
//  Description : Button/switch inputs and threshold outputs of the
//                time-set controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface time_set_controller_if;

    logic       btn_inc;
    logic       btn_dec;
    logic       btn_select;
    logic       is_standby;
    logic       reminder_duration_set_switch;
    logic       gesture_time_set_switch;

    logic [5:0] hour_threshold;
    logic [5:0] min_threshold;
    logic [5:0] second_gesture;
    logic [1:0] adjust_state;
    logic       settings_saved;

    modport master (
        output btn_inc,
        output btn_dec,
        output btn_select,
        output is_standby,
        output reminder_duration_set_switch,
        output gesture_time_set_switch,
        input  hour_threshold,
        input  min_threshold,
        input  second_gesture,
        input  adjust_state,
        input  settings_saved
    );

    modport slave (
        input  btn_inc,
        input  btn_dec,
        input  btn_select,
        input  is_standby,
        input  reminder_duration_set_switch,
        input  gesture_time_set_switch,
        output hour_threshold,
        output min_threshold,
        output second_gesture,
        output adjust_state,
        output settings_saved
    );

endinterface
`default_nettype wire

// File: rtl/time_set_controller_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : Synchronizer, debounce, rising-edge step pulse and optional
//                hold-to-repeat for one raw push-button.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 10,
    parameter int unsigned REPEAT_DELAY    = 250,
    parameter int unsigned REPEAT_PERIOD   = 50,
    parameter bit          REPEAT_EN       = 1'b0
) (
    input  wire  clk_500Hz,
    input  wire  rst_n,
    input  wire  btn_raw,
    output logic step
);

    localparam int unsigned c_db_w = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic [c_db_w-1:0] r_db_cnt;
    logic              r_level;
    logic              r_level_d;
    logic [1:0]        r_vld;
    logic              r_armed;
    logic              r_step;

    logic              w_rise;
    logic              w_rep_hit;

    // A button held through reset stays disarmed until it is seen released,
    // so it cannot fire a step when its debounced level first comes up.
    always_ff @(posedge clk_500Hz or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_db_cnt  <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_vld     <= 2'b00;
            r_armed   <= 1'b0;
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_vld     <= {r_vld[0], 1'b1};
            r_level_d <= r_level;
            if (r_vld[1] && !r_sync2) begin
                r_armed <= 1'b1;
            end
            if (r_sync2 == r_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_db_last) begin
                r_level  <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + c_db_w'(1);
            end
        end
    end

    assign w_rise = r_level & ~r_level_d;

    generate
        if (REPEAT_EN) begin : g_repeat
            localparam int unsigned c_hold_w = $clog2(REPEAT_DELAY + 1);
            localparam logic [c_hold_w-1:0] c_hold_last   = c_hold_w'(REPEAT_DELAY - 1);
            localparam logic [c_hold_w-1:0] c_hold_reload = c_hold_w'(REPEAT_DELAY - REPEAT_PERIOD);

            logic [c_hold_w-1:0] r_hold;

            // Reloading instead of counting on keeps the counter bounded for
            // arbitrarily long holds.
            always_ff @(posedge clk_500Hz or negedge rst_n) begin
                if (!rst_n) begin
                    r_hold <= '0;
                end else if (!r_level || w_rise) begin
                    r_hold <= '0;
                end else if (r_hold == c_hold_last) begin
                    r_hold <= c_hold_reload;
                end else begin
                    r_hold <= r_hold + c_hold_w'(1);
                end
            end

            assign w_rep_hit = r_level & r_level_d & (r_hold == c_hold_last);
        end else begin : g_no_repeat
            assign w_rep_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_500Hz or negedge rst_n) begin
        if (!rst_n) begin
            r_step <= 1'b0;
        end else begin
            r_step <= r_armed & (w_rise | w_rep_hit);
        end
    end

    assign step = r_step;

endmodule
`default_nettype wire

// File: rtl/time_set_controller.sv
`default_nettype none
// ============================================================================
//  Module      : time_set_controller
//  Description : Standby time-setting input path: conditions the buttons and
//                edits the reminder threshold and gesture time.
//  Revision    : 1.0 - initial release
// ============================================================================
module time_set_controller
    import time_set_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 10,
    parameter int unsigned REPEAT_DELAY    = 250,
    parameter int unsigned REPEAT_PERIOD   = 50,
    parameter int unsigned DEF_HOUR        = 10,
    parameter int unsigned DEF_MIN         = 0,
    parameter int unsigned DEF_GESTURE     = 5
) (
    input  wire                  clk_500Hz,
    input  wire                  rst_n,
    time_set_controller_if.slave bus
);

    logic              w_inc_step;
    logic              w_dec_step;
    logic              w_sel_step;
    step_t             w_step;

    logic [MODE_W-1:0] r_mode;
    logic [MODE_W-1:0] w_mode_next;
    logic              w_save;

    logic [5:0]        r_hour;
    logic [5:0]        r_min;
    logic [5:0]        r_gesture;
    logic [1:0]        r_adjust;
    logic              r_saved;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .REPEAT_EN       (1'b1)
    ) u_inc (
        .clk_500Hz (clk_500Hz),
        .rst_n     (rst_n),
        .btn_raw   (bus.btn_inc),
        .step      (w_inc_step)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .REPEAT_EN       (1'b1)
    ) u_dec (
        .clk_500Hz (clk_500Hz),
        .rst_n     (rst_n),
        .btn_raw   (bus.btn_dec),
        .step      (w_dec_step)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .REPEAT_EN       (1'b0)
    ) u_sel (
        .clk_500Hz (clk_500Hz),
        .rst_n     (rst_n),
        .btn_raw   (bus.btn_select),
        .step      (w_sel_step)
    );

    assign w_step = '{inc: w_inc_step, dec: w_dec_step, sel: w_sel_step};

    // r_mode remembers last cycle's mode so exits from an edit mode are seen.
    always_ff @(posedge clk_500Hz or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MODE_IDLE;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    // Reminder switch wins when both switches are up.
    always_comb begin
        w_mode_next = MODE_IDLE;
        if (bus.is_standby && bus.reminder_duration_set_switch) begin
            w_mode_next = MODE_REMINDER;
        end else if (bus.is_standby && bus.gesture_time_set_switch) begin
            w_mode_next = MODE_GESTURE;
        end
    end

    always_comb begin
        w_save = 1'b0;
        case (r_mode)
            MODE_REMINDER: w_save = (w_mode_next != MODE_REMINDER);
            MODE_GESTURE:  w_save = (w_mode_next == MODE_IDLE);
            default:       w_save = 1'b0;
        endcase
    end

    // The step uses the field selected before a same-cycle select toggle.
    always_ff @(posedge clk_500Hz or negedge rst_n) begin
        if (!rst_n) begin
            r_hour    <= 6'(DEF_HOUR);
            r_min     <= 6'(DEF_MIN);
            r_gesture <= 6'(DEF_GESTURE);
            r_adjust  <= ADJUST_MIN_REMINDER;
            r_saved   <= 1'b0;
        end else begin
            r_saved <= w_save;
            case (w_mode_next)
                MODE_REMINDER: begin
                    if (r_adjust == ADJUST_HOUR_REMINDER) begin
                        r_hour <= step_field(r_hour, w_step.inc, w_step.dec, 6'd0, HOUR_MAX);
                    end else begin
                        r_min <= step_field(r_min, w_step.inc, w_step.dec, 6'd0, MIN_MAX);
                    end
                    if (w_step.sel) begin
                        r_adjust <= (r_adjust == ADJUST_HOUR_REMINDER) ?
                                    ADJUST_MIN_REMINDER : ADJUST_HOUR_REMINDER;
                    end
                end
                MODE_GESTURE: begin
                    r_gesture <= step_field(r_gesture, w_step.inc, w_step.dec,
                                            GESTURE_MIN, GESTURE_MAX);
                    r_adjust  <= ADJUST_MIN_REMINDER;
                end
                default: begin
                    r_adjust <= ADJUST_MIN_REMINDER;
                end
            endcase
        end
    end

    assign bus.hour_threshold = r_hour;
    assign bus.min_threshold  = r_min;
    assign bus.second_gesture = r_gesture;
    assign bus.adjust_state   = r_adjust;
    assign bus.settings_saved = r_saved;

endmodule
`default_nettype wire

// File: tb/tb_time_set_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_set_controller
//  Description : Directed self-checking bench for time_set_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_time_set_controller;

    logic clk_500Hz = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    time_set_controller_if bus ();

    time_set_controller #(
        .DEBOUNCE_CYCLES (10),
        .REPEAT_DELAY    (250),
        .REPEAT_PERIOD   (50),
        .DEF_HOUR        (10),
        .DEF_MIN         (0),
        .DEF_GESTURE     (5)
    ) dut (
        .clk_500Hz (clk_500Hz),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    always #5 clk_500Hz = ~clk_500Hz;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns 1 time unit after the n-th rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_500Hz);
        #1;
    endtask

    task automatic press(input bit inc, input bit dec, input bit sel, input int hold);
        bus.btn_inc    = inc;
        bus.btn_dec    = dec;
        bus.btn_select = sel;
        tick(hold);
        bus.btn_inc    = 1'b0;
        bus.btn_dec    = 1'b0;
        bus.btn_select = 1'b0;
        tick(25);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n                            = 1'b0;
        bus.btn_inc                      = 1'b0;
        bus.btn_dec                      = 1'b0;
        bus.btn_select                   = 1'b0;
        bus.is_standby                   = 1'b0;
        bus.reminder_duration_set_switch = 1'b0;
        bus.gesture_time_set_switch      = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        check("rst_hour", bus.hour_threshold, 10);
        check("rst_min", bus.min_threshold, 0);
        check("rst_gest", bus.second_gesture, 5);
        check("rst_adj", bus.adjust_state, 0);
        check("rst_saved", bus.settings_saved, 0);
        tick(1000);
        check("hold_hour", bus.hour_threshold, 10);
        check("hold_min", bus.min_threshold, 0);
        check("hold_gest", bus.second_gesture, 5);

        // Reminder mode, minute field
        bus.is_standby                   = 1'b1;
        bus.reminder_duration_set_switch = 1'b1;
        tick(1);
        check("idle_to_rem_saved", bus.settings_saved, 0);
        bus.btn_inc = 1'b1;
        tick(13);
        check("lat_edge12", bus.min_threshold, 0);
        tick(1);
        check("lat_edge13", bus.min_threshold, 1);
        tick(6);
        bus.btn_inc = 1'b0;
        tick(25);
        press(1, 0, 0, 20);
        press(1, 0, 0, 20);
        check("min_three", bus.min_threshold, 3);
        press(1, 0, 0, 4);
        check("glitch", bus.min_threshold, 3);
        for (int i = 0; i < 4; i++) press(0, 1, 0, 20);
        check("min_wrap_down", bus.min_threshold, 59);
        press(1, 0, 0, 20);
        check("min_wrap_up", bus.min_threshold, 0);

        // Hour field
        press(0, 0, 1, 20);
        check("sel_hour", bus.adjust_state, 1);
        for (int i = 0; i < 10; i++) press(0, 1, 0, 20);
        check("hour_zero", bus.hour_threshold, 0);
        press(0, 1, 0, 20);
        check("hour_wrap_down", bus.hour_threshold, 23);
        press(1, 0, 0, 20);
        check("hour_wrap_up", bus.hour_threshold, 0);
        press(1, 1, 0, 20);
        check("inc_dec_cancel", bus.hour_threshold, 0);
        check("min_untouched", bus.min_threshold, 0);
        press(1, 0, 1, 20);
        check("sel_inc_hour", bus.hour_threshold, 1);
        check("sel_inc_adj", bus.adjust_state, 0);
        check("sel_inc_min", bus.min_threshold, 0);

        // Gesture mode with auto-repeat
        bus.reminder_duration_set_switch = 1'b0;
        bus.gesture_time_set_switch      = 1'b1;
        tick(1);
        check("rem_to_gest_saved", bus.settings_saved, 1);
        tick(1);
        check("saved_one_cycle", bus.settings_saved, 0);
        check("gest_adj", bus.adjust_state, 0);
        bus.btn_inc = 1'b1;
        tick(14);
        check("gest_first_step", bus.second_gesture, 6);
        tick(249);
        check("gest_before_rep", bus.second_gesture, 6);
        tick(1);
        check("gest_first_rep", bus.second_gesture, 7);
        tick(216);
        bus.btn_inc = 1'b0;
        tick(30);
        check("gest_repeat", bus.second_gesture, 11);
        for (int i = 0; i < 10; i++) press(0, 1, 0, 20);
        check("gest_one", bus.second_gesture, 1);
        press(0, 1, 0, 20);
        check("gest_wrap_down", bus.second_gesture, 59);
        press(1, 0, 0, 20);
        check("gest_wrap_up", bus.second_gesture, 1);

        // Not in standby
        bus.is_standby = 1'b0;
        tick(1);
        check("gest_to_idle_saved", bus.settings_saved, 1);
        press(1, 0, 0, 20);
        press(0, 1, 0, 20);
        press(0, 0, 1, 20);
        check("idle_gest", bus.second_gesture, 1);
        check("idle_min", bus.min_threshold, 0);
        check("idle_hour", bus.hour_threshold, 1);
        check("idle_adj", bus.adjust_state, 0);

        // Both switches: reminder wins
        bus.is_standby                   = 1'b1;
        bus.reminder_duration_set_switch = 1'b1;
        tick(1);
        check("idle_to_both_saved", bus.settings_saved, 0);
        press(1, 0, 0, 20);
        check("both_min", bus.min_threshold, 1);
        check("both_gest", bus.second_gesture, 1);
        press(0, 0, 1, 20);
        check("both_sel", bus.adjust_state, 1);
        bus.reminder_duration_set_switch = 1'b0;
        bus.gesture_time_set_switch      = 1'b0;
        tick(1);
        check("rem_to_idle_saved", bus.settings_saved, 1);
        check("rem_to_idle_adj", bus.adjust_state, 0);
        tick(1);
        check("rem_to_idle_once", bus.settings_saved, 0);
        bus.gesture_time_set_switch = 1'b1;
        tick(3);
        bus.reminder_duration_set_switch = 1'b1;
        tick(1);
        check("gest_to_rem_saved_a", bus.settings_saved, 0);
        tick(1);
        check("gest_to_rem_saved_b", bus.settings_saved, 0);

        // Reset in the middle of a hold
        for (int i = 0; i < 5; i++) press(1, 0, 0, 20);
        check("min_six", bus.min_threshold, 6);
        bus.btn_inc = 1'b1;
        tick(100);
        check("min_seven", bus.min_threshold, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_min", bus.min_threshold, 0);
        check("async_rst_hour", bus.hour_threshold, 10);
        check("async_rst_gest", bus.second_gesture, 5);
        tick(3);
        rst_n = 1'b1;
        tick(400);
        check("held_through_rst", bus.min_threshold, 0);
        bus.btn_inc = 1'b0;
        tick(30);
        check("released_no_step", bus.min_threshold, 0);
        press(1, 0, 0, 20);
        check("fresh_press", bus.min_threshold, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
